// File: rtl/rs_alu_bank.sv
// Reservation-station bank feeding a LATENCY-stage integer ALU.
// Entries snoop the CDB for missing operands; results leave through a valid/ready port.
module rs_alu_bank #(
  parameter int ENTRIES  = 4,
  parameter int DATA_W   = 32,
  parameter int TAG_W    = 3,
  parameter int TAG_BASE = 1,
  parameter int LATENCY  = 2
) (
  input  logic                              CLOCK_50,
  input  logic                              RSTN_N,
  input  logic                              flush,
  input  logic                              disp_valid,
  output logic                              disp_ready,
  input  logic [2:0]                        disp_op,
  input  logic [TAG_W-1:0]                  disp_tag1,
  input  logic [TAG_W-1:0]                  disp_tag2,
  input  logic [DATA_W-1:0]                 disp_val1,
  input  logic [DATA_W-1:0]                 disp_val2,
  output logic [TAG_W-1:0]                  disp_tag,
  input  logic                              cdb_valid,
  input  logic [TAG_W-1:0]                  cdb_tag,
  input  logic [DATA_W-1:0]                 cdb_data,
  output logic                              res_valid,
  input  logic                              res_ready,
  output logic [TAG_W-1:0]                  res_tag,
  output logic [DATA_W-1:0]                 res_data,
  output logic [$clog2(ENTRIES+1)-1:0]      busy_count
);

  localparam int CNT_W = $clog2(ENTRIES+1);
  localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  logic              e_busy   [ENTRIES];
  logic              e_issued [ENTRIES];
  logic [2:0]        e_op     [ENTRIES];
  logic [TAG_W-1:0]  e_tag1   [ENTRIES];
  logic [TAG_W-1:0]  e_tag2   [ENTRIES];
  logic [DATA_W-1:0] e_val1   [ENTRIES];
  logic [DATA_W-1:0] e_val2   [ENTRIES];

  logic              vld_p  [1:LATENCY];
  logic [TAG_W-1:0]  tag_p  [1:LATENCY];
  logic [DATA_W-1:0] data_p [1:LATENCY];

  logic             free_found, rdy_found;
  logic [IDX_W-1:0] free_idx, rdy_idx;
  logic [CNT_W-1:0] cnt;
  logic             advance, disp_fire, res_fire, issue_fire;

  function automatic logic [DATA_W-1:0] alu(input logic [2:0] op,
                                            input logic [DATA_W-1:0] a,
                                            input logic [DATA_W-1:0] b);
    logic signed [DATA_W-1:0] sa;
    logic signed [DATA_W-1:0] sb;
    sa = a;
    sb = b;
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return {{(DATA_W-1){1'b0}}, (sa < sb)};
      3'd3:    return {{(DATA_W-1){1'b0}}, (a < b)};
      3'd4:    return a & b;
      3'd5:    return a | b;
      3'd6:    return a ^ b;
      default: return '0;
    endcase
  endfunction

  // Tag 0 marks a present value, so it can never be a snoop hit.
  function automatic logic snoop_hit(input logic [TAG_W-1:0] t);
    return cdb_valid && (t != '0) && (t == cdb_tag);
  endfunction

  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    rdy_found  = 1'b0;
    rdy_idx    = '0;
    cnt        = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (e_busy[i]) cnt = cnt + CNT_W'(1);
      if (!e_busy[i] && !free_found) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
      if (e_busy[i] && !e_issued[i] && (e_tag1[i] == '0) && (e_tag2[i] == '0) && !rdy_found) begin
        rdy_found = 1'b1;
        rdy_idx   = IDX_W'(i);
      end
    end
  end

  assign disp_ready = free_found;
  assign disp_tag   = TAG_W'(TAG_BASE) + TAG_W'(free_idx);
  assign busy_count = cnt;
  assign advance    = !(vld_p[LATENCY] && !res_ready);
  assign disp_fire  = disp_valid && disp_ready;
  assign res_fire   = vld_p[LATENCY] && res_ready;
  assign issue_fire = advance && rdy_found;

  assign res_valid = vld_p[LATENCY];
  assign res_tag   = tag_p[LATENCY];
  assign res_data  = data_p[LATENCY];

  always_ff @(posedge CLOCK_50 or negedge RSTN_N) begin
    if (!RSTN_N) begin
      for (int i = 0; i < ENTRIES; i++) begin
        e_busy[i]   <= 1'b0;
        e_issued[i] <= 1'b0;
        e_op[i]     <= '0;
        e_tag1[i]   <= '0;
        e_tag2[i]   <= '0;
        e_val1[i]   <= '0;
        e_val2[i]   <= '0;
      end
      for (int s = 1; s <= LATENCY; s++) begin
        vld_p[s]  <= 1'b0;
        tag_p[s]  <= '0;
        data_p[s] <= '0;
      end
    end else if (flush) begin
      for (int i = 0; i < ENTRIES; i++) begin
        e_busy[i]   <= 1'b0;
        e_issued[i] <= 1'b0;
      end
      for (int s = 1; s <= LATENCY; s++) vld_p[s] <= 1'b0;
    end else begin
      // Entry stage: snoop, free on handshake, mark issue, allocate on dispatch
      for (int i = 0; i < ENTRIES; i++) begin
        if (e_busy[i]) begin
          if (snoop_hit(e_tag1[i])) begin
            e_tag1[i] <= '0;
            e_val1[i] <= cdb_data;
          end
          if (snoop_hit(e_tag2[i])) begin
            e_tag2[i] <= '0;
            e_val2[i] <= cdb_data;
          end
        end
        if (res_fire && (tag_p[LATENCY] == TAG_W'(TAG_BASE + i))) begin
          e_busy[i]   <= 1'b0;
          e_issued[i] <= 1'b0;
        end
        if (issue_fire && (rdy_idx == IDX_W'(i))) e_issued[i] <= 1'b1;
        if (disp_fire && (free_idx == IDX_W'(i))) begin
          e_busy[i]   <= 1'b1;
          e_issued[i] <= 1'b0;
          e_op[i]     <= disp_op;
          e_tag1[i]   <= snoop_hit(disp_tag1) ? '0 : disp_tag1;
          e_val1[i]   <= snoop_hit(disp_tag1) ? cdb_data : disp_val1;
          e_tag2[i]   <= snoop_hit(disp_tag2) ? '0 : disp_tag2;
          e_val2[i]   <= snoop_hit(disp_tag2) ? cdb_data : disp_val2;
        end
      end
      // ALU stages p1..pLATENCY: compute at issue, then shift toward the result port
      if (advance) begin
        vld_p[1] <= issue_fire;
        if (issue_fire) begin
          tag_p[1]  <= TAG_W'(TAG_BASE) + TAG_W'(rdy_idx);
          data_p[1] <= alu(e_op[rdy_idx], e_val1[rdy_idx], e_val2[rdy_idx]);
        end
        for (int s = 2; s <= LATENCY; s++) begin
          vld_p[s]  <= vld_p[s-1];
          tag_p[s]  <= tag_p[s-1];
          data_p[s] <= data_p[s-1];
        end
      end
    end
  end

endmodule

// File: tb/tb_rs_alu_bank.sv
// Bench for rs_alu_bank: scoreboard of expected results, a tag-allocation model,
// an ALU vector table and directed multi-cycle sequences.
module tb_rs_alu_bank;

  logic        CLOCK_50 = 1'b0;
  logic        RSTN_N = 1'b0;
  logic        flush = 1'b0;
  logic        disp_valid = 1'b0;
  logic        disp_ready;
  logic [2:0]  disp_op = '0;
  logic [2:0]  disp_tag1 = '0, disp_tag2 = '0;
  logic [31:0] disp_val1 = '0, disp_val2 = '0;
  logic [2:0]  disp_tag;
  logic        cdb_valid = 1'b0;
  logic [2:0]  cdb_tag = '0;
  logic [31:0] cdb_data = '0;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [2:0]  res_tag;
  logic [31:0] res_data;
  logic [2:0]  busy_count;

  rs_alu_bank #(.ENTRIES(4), .DATA_W(32), .TAG_W(3), .TAG_BASE(1), .LATENCY(2)) dut (
    .CLOCK_50(CLOCK_50), .RSTN_N(RSTN_N), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_op(disp_op),
    .disp_tag1(disp_tag1), .disp_tag2(disp_tag2),
    .disp_val1(disp_val1), .disp_val2(disp_val2), .disp_tag(disp_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .res_valid(res_valid), .res_ready(res_ready), .res_tag(res_tag),
    .res_data(res_data), .busy_count(busy_count));

  always #5 CLOCK_50 = ~CLOCK_50;

  typedef struct {
    logic [2:0]  tag;
    logic [31:0] data;
  } exp_t;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  exp_t q[$];
  bit   mbusy [1:4];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int lowest_free();
    for (int t = 1; t <= 4; t++) if (!mbusy[t]) return t;
    return 0;
  endfunction

  task automatic model_clear();
    for (int t = 1; t <= 4; t++) mbusy[t] = 1'b0;
  endtask

  // Scoreboard: every handshake must match the oldest outstanding expectation.
  always @(negedge CLOCK_50) begin
    if (RSTN_N && res_valid && res_ready) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_result: got tag %0d data %0h, none expected", res_tag, res_data);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("res_tag", 32'(res_tag), 32'(e.tag));
        chk("res_data", res_data, e.data);
        mbusy[e.tag] = 1'b0;
      end
    end
  end

  task automatic dispatch(input logic [2:0] op, input logic [2:0] t1, input logic [31:0] v1,
                          input logic [2:0] t2, input logic [31:0] v2,
                          input logic [31:0] exp, input bit push);
    int n = 0;
    int et;
    while (lowest_free() == 0 && n < 50) begin
      @(posedge CLOCK_50); #1;
      n++;
    end
    et = lowest_free();
    if (et == 0) begin
      tests++;
      fails++;
      $display("FAIL dispatch_wait: got no free entry expected one within 50 cycles");
      return;
    end
    chk("disp_ready", 32'(disp_ready), 32'd1);
    chk("disp_tag", 32'(disp_tag), 32'(et));
    disp_valid = 1'b1;
    disp_op = op; disp_tag1 = t1; disp_val1 = v1; disp_tag2 = t2; disp_val2 = v2;
    mbusy[et] = 1'b1;
    if (push) q.push_back('{tag: 3'(et), data: exp});
    @(posedge CLOCK_50); #1;
    disp_valid = 1'b0;
  endtask

  task automatic broadcast(input logic [2:0] t, input logic [31:0] d);
    cdb_valid = 1'b1; cdb_tag = t; cdb_data = d;
    @(posedge CLOCK_50); #1;
    cdb_valid = 1'b0; cdb_tag = '0;
  endtask

  task automatic drain(input int max);
    int n = 0;
    while (q.size() != 0 && n < max) begin
      @(posedge CLOCK_50); #1;
      n++;
    end
    chk("drain_left", 32'(q.size()), 32'd0);
  endtask

  task automatic wait_res_valid(input int max);
    int n = 0;
    while (!res_valid && n < max) begin
      @(negedge CLOCK_50);
      n++;
    end
    chk("res_valid_wait", 32'(res_valid), 32'd1);
  endtask

  vec_t vecs [13];

  initial begin
    vecs[0]  = '{3'd0, 32'hFFFF_FFFF, 32'h1,         32'h0};
    vecs[1]  = '{3'd1, 32'h0,         32'h1,         32'hFFFF_FFFF};
    vecs[2]  = '{3'd1, 32'd10,        32'd3,         32'd7};
    vecs[3]  = '{3'd2, 32'hFFFF_FFFF, 32'h1,         32'h1};
    vecs[4]  = '{3'd3, 32'hFFFF_FFFF, 32'h1,         32'h0};
    vecs[5]  = '{3'd2, 32'h1,         32'hFFFF_FFFF, 32'h0};
    vecs[6]  = '{3'd3, 32'h1,         32'hFFFF_FFFF, 32'h1};
    vecs[7]  = '{3'd2, 32'h8000_0000, 32'h7FFF_FFFF, 32'h1};
    vecs[8]  = '{3'd4, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000};
    vecs[9]  = '{3'd5, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0};
    vecs[10] = '{3'd6, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0};
    vecs[11] = '{3'd7, 32'h1234_5678, 32'h1,         32'h0};
    vecs[12] = '{3'd2, 32'd5,         32'd5,         32'h0};
    model_clear();

    repeat (3) @(posedge CLOCK_50);
    #1 RSTN_N = 1'b1;
    @(negedge CLOCK_50);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_tag", 32'(res_tag), 32'd0);
    chk("rst_res_data", res_data, 32'd0);
    chk("rst_busy_count", 32'(busy_count), 32'd0);
    chk("rst_disp_ready", 32'(disp_ready), 32'd1);
    chk("rst_disp_tag", 32'(disp_tag), 32'd1);

    // Minimum latency ADD
    @(posedge CLOCK_50); #1;
    res_ready = 1'b1;
    dispatch(3'd0, 3'd0, 32'd5, 3'd0, 32'd7, 32'd12, 1'b1);
    @(negedge CLOCK_50);
    chk("lat_busy_t1", 32'(busy_count), 32'd1);
    chk("lat_valid_t1", 32'(res_valid), 32'd0);
    @(negedge CLOCK_50);
    chk("lat_valid_t2", 32'(res_valid), 32'd0);
    @(negedge CLOCK_50);
    chk("lat_valid_t3", 32'(res_valid), 32'd1);
    @(negedge CLOCK_50);
    chk("lat_busy_after", 32'(busy_count), 32'd0);
    drain(10);

    // SUB waiting on an operand broadcast three cycles later
    @(posedge CLOCK_50); #1;
    dispatch(3'd1, 3'd3, 32'hDEAD_BEEF, 3'd0, 32'd1, 32'hFFFF_FFFF, 1'b1);
    repeat (2) begin @(posedge CLOCK_50); #1; end
    broadcast(3'd3, 32'd0);
    @(negedge CLOCK_50);
    chk("cdb_valid_c1", 32'(res_valid), 32'd0);
    @(negedge CLOCK_50);
    chk("cdb_valid_c2", 32'(res_valid), 32'd0);
    @(negedge CLOCK_50);
    chk("cdb_valid_c3", 32'(res_valid), 32'd1);
    chk("cdb_tag_c3", 32'(res_tag), 32'd1);
    drain(10);

    // ALU vector table, back-to-back dispatch
    for (int i = 0; i < 13; i++)
      dispatch(vecs[i].op, 3'd0, vecs[i].a, 3'd0, vecs[i].b, vecs[i].exp, 1'b1);
    drain(40);

    // Fill all entries on tag 7, then wake them with one broadcast
    dispatch(3'd0, 3'd7, 32'd0, 3'd0, 32'd1, 32'd3, 1'b1);
    dispatch(3'd1, 3'd7, 32'd0, 3'd0, 32'd1, 32'd1, 1'b1);
    dispatch(3'd6, 3'd7, 32'd0, 3'd7, 32'd0, 32'd0, 1'b1);
    dispatch(3'd5, 3'd0, 32'd8, 3'd7, 32'd0, 32'd10, 1'b1);
    chk("full_disp_ready", 32'(disp_ready), 32'd0);
    chk("full_busy_count", 32'(busy_count), 32'd4);
    broadcast(3'd7, 32'd2);
    repeat (2) @(negedge CLOCK_50);
    for (int k = 0; k < 4; k++) begin
      @(negedge CLOCK_50);
      chk("wake_res_valid", 32'(res_valid), 32'd1);
      chk("wake_res_tag", 32'(res_tag), 32'(k + 1));
      if (k == 0) chk("wake_full_ready", 32'(disp_ready), 32'd0);
      if (k == 1) chk("wake_freed_ready", 32'(disp_ready), 32'd1);
    end
    drain(10);

    // Stall with three ready entries
    res_ready = 1'b0;
    dispatch(3'd0, 3'd0, 32'd1, 3'd0, 32'd1, 32'd2, 1'b1);
    dispatch(3'd0, 3'd0, 32'd2, 3'd0, 32'd2, 32'd4, 1'b1);
    dispatch(3'd0, 3'd0, 32'd3, 3'd0, 32'd3, 32'd6, 1'b1);
    wait_res_valid(20);
    for (int k = 0; k < 5; k++) begin
      @(negedge CLOCK_50);
      chk("stall_valid", 32'(res_valid), 32'd1);
      chk("stall_tag", 32'(res_tag), 32'd1);
      chk("stall_data", res_data, 32'd2);
      chk("stall_busy", 32'(busy_count), 32'd3);
    end
    @(posedge CLOCK_50); #1;
    res_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLOCK_50);
      chk("release_valid", 32'(res_valid), 32'd1);
      chk("release_tag", 32'(res_tag), 32'(k + 1));
    end
    @(negedge CLOCK_50);
    chk("release_empty", 32'(res_valid), 32'd0);
    drain(10);

    // Same-cycle CDB bypass at dispatch
    @(posedge CLOCK_50); #1;
    cdb_valid = 1'b1; cdb_tag = 3'd5; cdb_data = 32'd9;
    dispatch(3'd0, 3'd5, 32'd0, 3'd0, 32'd4, 32'd13, 1'b1);
    cdb_valid = 1'b0; cdb_tag = '0;
    drain(20);

    // Flush with entries waiting and a result in flight
    res_ready = 1'b0;
    dispatch(3'd0, 3'd0, 32'd1, 3'd0, 32'd2, 32'd0, 1'b0);
    dispatch(3'd0, 3'd6, 32'd0, 3'd0, 32'd2, 32'd0, 1'b0);
    dispatch(3'd0, 3'd0, 32'd3, 3'd6, 32'd0, 32'd0, 1'b0);
    @(negedge CLOCK_50);
    chk("preflush_valid", 32'(res_valid), 32'd1);
    chk("preflush_busy", 32'(busy_count), 32'd3);
    @(posedge CLOCK_50); #1;
    flush = 1'b1;
    @(posedge CLOCK_50); #1;
    flush = 1'b0;
    model_clear();
    @(negedge CLOCK_50);
    chk("flush_valid", 32'(res_valid), 32'd0);
    chk("flush_busy", 32'(busy_count), 32'd0);
    chk("flush_disp_tag", 32'(disp_tag), 32'd1);
    chk("flush_disp_ready", 32'(disp_ready), 32'd1);
    @(posedge CLOCK_50); #1;
    res_ready = 1'b1;
    broadcast(3'd6, 32'd5);
    repeat (6) @(negedge CLOCK_50);
    chk("flush_quiet_busy", 32'(busy_count), 32'd0);

    // Asynchronous reset during a stall
    @(posedge CLOCK_50); #1;
    res_ready = 1'b0;
    dispatch(3'd0, 3'd0, 32'd3, 3'd0, 32'd4, 32'd0, 1'b0);
    wait_res_valid(20);
    @(posedge CLOCK_50); #2;
    RSTN_N = 1'b0;
    #1;
    chk("arst_res_valid", 32'(res_valid), 32'd0);
    chk("arst_res_tag", 32'(res_tag), 32'd0);
    chk("arst_res_data", res_data, 32'd0);
    chk("arst_busy", 32'(busy_count), 32'd0);
    chk("arst_disp_ready", 32'(disp_ready), 32'd1);
    model_clear();
    #3 RSTN_N = 1'b1;
    @(posedge CLOCK_50); #1;
    res_ready = 1'b1;
    dispatch(3'd0, 3'd0, 32'd20, 3'd0, 32'd22, 32'd42, 1'b1);
    drain(20);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected bench completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/rs_alu_bank.md
# rs_alu_bank

Parametrised reservation-station bank with a pipelined integer ALU behind it: the next-generation replacement for the single-slot, fixed one-cycle-delay adder in the out-of-order core. It holds `ENTRIES` waiting instructions and captures missing operands by snooping the common data bus (CDB). It issues one ready entry per cycle into a `LATENCY`-stage ALU pipeline and offers results to the CDB arbiter with a valid/ready handshake. Each entry owns a fixed tag; tag 0 always means "operand value present".

## Interface
- `ENTRIES`, 4, number of reservation entries (1..15).
- `DATA_W`, 32, operand/result width.
- `TAG_W`, 3, tag width; requires `TAG_BASE+ENTRIES-1 < 2**TAG_W`.
- `TAG_BASE`, 1, tag of entry 0; entry i owns tag `TAG_BASE+i`; must be ≥1.
- `LATENCY`, 2, ALU pipeline stages (≥1).

Ports:
- `CLOCK_50`  in  1  clock, rising edge.
- `RSTN_N`  in  1  asynchronous active-low reset.
- `flush`  in  1  synchronous clear of all entries and pipeline.
- `disp_valid`  in  1  dispatch request.
- `disp_ready`  out  1  at least one entry free (from registered state).
- `disp_op`  in  3  0 ADD, 1 SUB, 2 SLT, 3 SLTU, 4 AND, 5 OR, 6 XOR, 7 reserved.
- `disp_tag1` / `disp_tag2`  in  TAG_W  producer tag of rs1/rs2; 0 = value valid.
- `disp_val1` / `disp_val2`  in  DATA_W  operand values, used when tag is 0.
- `disp_tag`  out  TAG_W  tag that the next accepted dispatch receives (lowest free entry); the rename table stores it for rd.
- `cdb_valid`  in  1  CDB broadcast valid.
- `cdb_tag`  in  TAG_W  broadcast tag.
- `cdb_data`  in  DATA_W  broadcast value.
- `res_valid`  out  1  result offered.
- `res_ready`  in  1  arbiter grants the result; handshake cycle equals the CDB broadcast cycle.
- `res_tag`  out  TAG_W  tag of offered result.
- `res_data`  out  DATA_W  offered result.
- `busy_count`  out  $clog2(ENTRIES+1)  number of occupied entries.

## Operation
- Entry state: busy, issued, op, tag1/val1, tag2/val2. All entries start free.
- Dispatch: on `disp_valid && disp_ready`, the lowest-index free entry is written and marked busy, not issued. A dispatch while `disp_ready`=0 is ignored.
- Same-cycle bypass: if `cdb_valid` is high and `cdb_tag` equals a nonzero `disp_tagN`, the entry stores `cdb_data` with tag 0.
- Snoop: every busy entry whose tagN equals a valid nonzero `cdb_tag` captures `cdb_data` and sets tagN=0. Both operands may match in the same cycle. `cdb_tag`=0 is never a match.
- Issue: an entry is ready when it is busy, not issued, and both tags are 0. It reads registered operands, so a value captured this cycle is issued next cycle at the earliest. When the pipeline advances, the lowest-index ready entry enters stage 1 and is marked issued. At most one issue per cycle.
- Pipeline advance: `!(res_valid && !res_ready)`. A stall freezes all stages and blocks issue.
- The entry is freed (busy=0) in the cycle its result handshakes. It is allocatable from the next cycle, so a tag is never reused before its broadcast.
- Arithmetic:
  - ADD and SUB wrap modulo 2^DATA_W.
  - SLT is signed and SLTU is unsigned; both give 1 or 0, zero-extended.
  - AND/OR/XOR are bitwise.
  - Op 7 yields 0 but still handshakes and frees its entry.
- Flush: at the next edge, all entries are freed and all pipeline valid bits are cleared. Any dispatch, snoop or issue in the flush cycle is discarded. A result handshake in the flush cycle still counts as broadcast.

## Timing
- Reset values:
  - `res_valid`=0, `res_tag`=0, `res_data`=0, `busy_count`=0.
  - `disp_ready`=1, `disp_tag`=TAG_BASE.
  - All entries and stages cleared.
- Minimum latency: dispatch handshake in cycle T with both tags 0 gives issue in T+1 and `res_valid` from cycle T+1+LATENCY.
- Operand arriving on the CDB in cycle C gives earliest issue C+1 and result C+1+LATENCY.
- Throughput: one result per cycle while `res_ready` stays high.
- `res_valid/res_tag/res_data` are registered and held stable while `res_ready`=0.
- `busy_count` and `disp_ready` update at the edge after a dispatch or free. A simultaneous dispatch and free leaves the count unchanged.
- Full: `disp_ready`=0 until the cycle after a handshake.
- Reset mid-operation clears all state immediately (asynchronously).

## Test plan
- Reset, then dispatch ADD with val1=5, val2=7, tags 0 at cycle T, `res_ready`=1 → `res_valid` in T+3 (LATENCY=2), `res_tag`=1, `res_data`=12; `busy_count` 1→0.
- Dispatch SUB with tag1=3, val2=1. Broadcast cdb_tag=3, data=0 three cycles later → result 0xFFFFFFFF. SLT -1,1 gives 1; SLTU gives 0.
- Fill 4 entries whose operands wait on tag 7 → `disp_ready`=0, `busy_count`=4. Broadcast tag 7 with data 2 → results issue lowest index first, tags 1,2,3,4 on consecutive cycles.
- Hold `res_ready`=0 for 5 cycles with 3 ready entries → `res_valid`, `res_tag` and `res_data` stay stable and no entry is freed. Release → remaining results follow back-to-back.
- Dispatch with disp_tag1=5 in the same cycle as cdb_tag=5, data=9 → captures 9; result produced without any further broadcast.
- Assert `flush` with 2 entries busy and 1 result in flight → next cycle `res_valid`=0, `busy_count`=0, `disp_tag`=1. Assert `RSTN_N`=0 mid-stall → outputs go to reset values immediately.
